cpu5_core_mc: RTL and testbench
===============================

CPU5_CORE_MC -- requirements
Module: cpu5_core_mc

Interface
REQ-001 Parameter XLEN, default 32: width of PC, instruction, address and data buses.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1 / imem_addr  out  XLEN: instruction fetch request and address.
REQ-007 imem_ack  in  1 / imem_rdata  in  XLEN: fetch acknowledge and instruction word.
REQ-008 dmem_req  out  1 / dmem_we  out  1 / dmem_addr  out  XLEN / dmem_wdata  out  XLEN: data request, write enable, address, store data.
REQ-009 dmem_ack  in  1 / dmem_rdata  in  XLEN: data acknowledge and load data.
REQ-010 memtoreg, memwrite, regwrite  in  1 each: decode flags from cpu5_controller for the current IR.
REQ-011 alu_result  in  XLEN / store_data  in  XLEN / next_pc  in  XLEN: datapath results for the current IR.
REQ-012 pc  out  XLEN / instr  out  XLEN: architectural PC and latched instruction register (IR).
REQ-013 rf_we  out  1 / rf_wdata  out  XLEN: register-file write strobe and data.
REQ-014 instret  out  CNT_W: retired-instruction count; fault  out  1: sticky misaligned-fetch flag.

Function
REQ-015 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT; one state per cycle minimum.
REQ-016 FETCH: imem_req=1, imem_addr=pc; stay until imem_ack=1; on ack latch imem_rdata into IR, go DECODE.
REQ-017 imem_ack/dmem_ack sampled only while the matching req is 1; acks with req low ignored.
REQ-018 Zero-wait memory allowed: ack in the first req cycle completes the access that cycle.
REQ-019 req and address/data/we held stable from assertion until the ack cycle inclusive; req drops the cycle after ack.
REQ-020 DECODE: one cycle, no memory activity; go EXEC.
REQ-021 EXEC: latch alu_result, store_data, next_pc into internal registers; go MEM if memtoreg|memwrite, else WB.
REQ-022 MEM: dmem_req=1, dmem_addr=latched alu_result, dmem_we=memwrite, dmem_wdata=latched store_data; on ack latch dmem_rdata if load, go WB.
REQ-023 WB: rf_we=regwrite for exactly one cycle; rf_wdata=load data if memtoreg else latched alu_result; pc<=latched next_pc; instret+=1; go FETCH.
REQ-024 instret wraps modulo 2^CNT_W, no saturation.
REQ-025 Before entering FETCH, if pc[1:0]!=0: no imem_req, fault<=1, go HALT.
REQ-026 HALT: all req and rf_we 0, pc/instret frozen; exit only via reset.
REQ-027 rf_we, imem_req, dmem_req are 0 in every state not listed above as asserting them.
REQ-028 Minimum latency: ALU instruction 4 cycles (FETCH..WB), load/store 5 cycles, with zero-wait memory.

Reset
REQ-029 reset low asynchronously forces: state=FETCH, pc=RESET_PC, IR=0, instret=0, fault=0, all req/we/rf_we=0.
REQ-030 Reset mid-access (req high, ack pending) abandons the access; first request after release is a fetch at RESET_PC.
REQ-031 FETCH entered from reset issues imem_req on the first clock edge after reset deasserts.

Verification
REQ-032 Zero-wait ALU op: imem_ack same cycle, regwrite=1, alu_result=0x5, next_pc=0x4 -> rf_we one pulse with rf_wdata=0x5, pc=0x4, instret=1, 4 cycles total.
REQ-033 Load with 3 wait states: memtoreg=1, alu_result=0x100, dmem_ack after 3 req cycles, dmem_rdata=0xDEADBEEF -> dmem_addr=0x100 stable 4 cycles, dmem_we=0, rf_wdata=0xDEADBEEF.
REQ-034 Store: memwrite=1, regwrite=0, store_data=0x1234 -> dmem_we=1, dmem_wdata=0x1234, no rf_we pulse, instret increments.
REQ-035 Spurious ack: imem_ack pulsed in DECODE/EXEC -> no IR change, no state change.
REQ-036 Misaligned: next_pc=0x6 -> WB completes, then fault=1, state HALT, no further imem_req until reset.
REQ-037 Reset asserted during MEM wait -> dmem_req drops immediately; after release imem_addr=RESET_PC, instret=0.

Source files
------------

// File: rtl/cpu5_core_mc_if.sv
// cpu5_core_mc_if: instruction and data memory request/acknowledge buses
interface cpu5_core_mc_if #(parameter int XLEN = 32);
  logic            imem_req, imem_ack;
  logic [XLEN-1:0] imem_addr, imem_rdata;
  logic            dmem_req, dmem_we, dmem_ack;
  logic [XLEN-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu5_core_mc.sv
// cpu5_core_mc: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with misaligned-fetch halt
module cpu5_core_mc #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  cpu5_core_mc_if.master    bus,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   next_pc,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   instr,
  output logic              rf_we,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [CNT_W-1:0]  instret,
  output logic              fault
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] alu_q, sd_q, npc_q, load_q;
  logic m2r_q, mw_q, rw_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   state_nx = |pc[1:0] ? HALT : (bus.imem_ack ? DECODE : FETCH);
      DECODE:  state_nx = EXEC;
      EXEC:    state_nx = (memtoreg | memwrite) ? MEM : WB;
      MEM:     state_nx = bus.dmem_ack ? WB : MEM;
      WB:      state_nx = |npc_q[1:0] ? HALT : FETCH;
      default: state_nx = HALT;
    endcase
  end
  // imem_req is gated by reset so nothing is requested while reset is held
  always_comb begin
    bus.imem_req   = reset && state == FETCH && pc[1:0] == 2'b00;
    bus.imem_addr  = pc;
    bus.dmem_req   = state == MEM;
    bus.dmem_we    = bus.dmem_req && mw_q;
    bus.dmem_addr  = alu_q;
    bus.dmem_wdata = sd_q;
    rf_we          = state == WB && rw_q;
    rf_wdata       = m2r_q ? load_q : alu_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
      fault   <= 1'b0;
      alu_q   <= '0;
      sd_q    <= '0;
      npc_q   <= '0;
      load_q  <= '0;
      m2r_q   <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
    end else begin
      if (bus.imem_req && bus.imem_ack) instr <= bus.imem_rdata;
      if (state == EXEC) begin
        alu_q <= alu_result;
        sd_q  <= store_data;
        npc_q <= next_pc;
        m2r_q <= memtoreg;
        mw_q  <= memwrite;
        rw_q  <= regwrite;
      end
      if (bus.dmem_req && bus.dmem_ack && m2r_q) load_q <= bus.dmem_rdata;
      if (state == WB) begin
        pc      <= npc_q;
        instret <= instret + CNT_W'(1);
      end
      if (state != HALT && state_nx == HALT) fault <= 1'b1;
    end
endmodule

// File: tb/tb_cpu5_core_mc.sv
// tb_cpu5_core_mc: randomized wait-state memory responder with a per-instruction reference model
module tb_cpu5_core_mc;
  logic        clk = 1'b0;
  logic        reset;
  logic        memtoreg, memwrite, regwrite, rf_we, fault;
  logic [31:0] alu_result, store_data, next_pc, pc, instr, rf_wdata, instret;
  logic [31:0] pc_m, instret_m;
  int checks = 0;
  int errors = 0;

  cpu5_core_mc_if #(.XLEN(32)) bus();

  cpu5_core_mc #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .memtoreg(memtoreg), .memwrite(memwrite), .regwrite(regwrite),
    .alu_result(alu_result), .store_data(store_data), .next_pc(next_pc),
    .pc(pc), .instr(instr), .rf_we(rf_we), .rf_wdata(rf_wdata),
    .instret(instret), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_instr(input int kind, input int iw, input int dw, input bit rw,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic [31:0] npc, input logic [31:0] rd);
    logic [31:0] iword, rfd;
    int cyc, ic, dc, rfp, exp_cyc;
    bit done, idone, bad;
    iword = $urandom;
    memtoreg = kind == 1;
    memwrite = kind == 2;
    regwrite = rw;
    alu_result = alu;
    store_data = sd;
    next_pc = npc;
    cyc = 0; ic = 0; dc = 0; rfp = 0; rfd = '0;
    done = 0; idone = 0; bad = 0;
    while (!done && cyc < 60) begin
      if ((bus.imem_req && idone) || fault) done = 1;
      else begin
        cyc++;
        if (bus.imem_req) begin
          if (bus.imem_addr !== pc_m) bad = 1;
          ic++;
          bus.imem_ack = ic == iw + 1;
          bus.imem_rdata = bus.imem_ack ? iword : $urandom;
          if (bus.imem_ack) idone = 1;
        end else begin
          bus.imem_ack = 1'($urandom_range(0, 1));
          bus.imem_rdata = $urandom;
        end
        if (bus.dmem_req) begin
          if (bus.dmem_addr !== alu || bus.dmem_we !== (kind == 2)) bad = 1;
          if (kind == 2 && bus.dmem_wdata !== sd) bad = 1;
          dc++;
          bus.dmem_ack = dc == dw + 1;
          bus.dmem_rdata = bus.dmem_ack ? rd : $urandom;
        end else begin
          bus.dmem_ack = 1'($urandom_range(0, 1));
          bus.dmem_rdata = $urandom;
        end
        if (rf_we) begin
          rfp++;
          rfd = rf_wdata;
        end
        step();
      end
    end
    exp_cyc = (iw + 1) + 2 + (kind != 0 ? dw + 1 : 0) + 1;
    instret_m = instret_m + 1;
    pc_m = npc;
    chk("completed", 32'(done), 32'd1);
    chk("latency", cyc, exp_cyc);
    chk("ir", instr, iword);
    chk("bus_fields", 32'(bad), 32'd0);
    chk("dmem_cycles", dc, kind != 0 ? dw + 1 : 0);
    chk("rf_pulses", rfp, rw ? 1 : 0);
    if (rw) chk("rf_wdata", rfd, kind == 1 ? rd : alu);
    chk("pc", pc, pc_m);
    chk("instret", instret, instret_m);
  endtask

  initial begin
    int k, iw, dw;
    bit rw, hbad;
    logic [31:0] npc;
    reset = 1'b0;
    memtoreg = 0; memwrite = 0; regwrite = 0;
    alu_result = 0; store_data = 0; next_pc = 0;
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.dmem_ack = 0; bus.dmem_rdata = 0;
    pc_m = 0; instret_m = 0;
    repeat (2) step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", instr, 32'h0);
    chk("rst_instret", instret, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b1;
    #1;
    chk("first_fetch_req", 32'(bus.imem_req), 32'd1);
    chk("first_fetch_addr", bus.imem_addr, 32'h0);

    run_instr(0, 0, 0, 1'b1, 32'h5, 32'h0, 32'h4, 32'h0);
    run_instr(1, 0, 3, 1'b1, 32'h100, 32'h0, 32'h8, 32'hDEADBEEF);
    run_instr(2, 1, 0, 1'b0, 32'h104, 32'h1234, 32'hC, 32'h0);

    for (int n = 0; n < 24; n++) begin
      k = $urandom_range(0, 2);
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      rw = k == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      npc = $urandom_range(0, 1) ? pc_m + 32'h4 : ($urandom & 32'hFFFF_FFFC);
      run_instr(k, iw, dw, rw, $urandom, $urandom, npc, $urandom);
    end

    memtoreg = 1; memwrite = 0; regwrite = 1;
    alu_result = 32'h200; next_pc = pc_m + 32'h4;
    bus.imem_ack = 1; bus.imem_rdata = $urandom; bus.dmem_ack = 0;
    step();
    bus.imem_ack = 0;
    repeat (3) step();
    chk("mem_wait_req", 32'(bus.dmem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("abort_imem_req", 32'(bus.imem_req), 32'd0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_instret", instret, 32'h0);
    step();
    reset = 1'b1;
    #1;
    pc_m = 0; instret_m = 0;
    chk("refetch_req", 32'(bus.imem_req), 32'd1);
    chk("refetch_addr", bus.imem_addr, 32'h0);
    run_instr(0, 2, 0, 1'b1, 32'hA5A5_0001, 32'h0, 32'h4, 32'h0);
    run_instr(1, 0, 0, 1'b1, 32'h40, 32'h0, 32'h8, 32'hCAFE_F00D);

    run_instr(0, 0, 0, 1'b1, 32'h77, 32'h0, 32'h6, 32'h0);
    chk("fault_set", 32'(fault), 32'd1);
    hbad = 0;
    repeat (6) begin
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      step();
      if (bus.imem_req || bus.dmem_req || rf_we || pc !== 32'h6 || instret !== instret_m || !fault) hbad = 1;
    end
    chk("halt_quiet", 32'(hbad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
